// File: rtl/add_round_key_stage_pkg.sv
// Shared AES round-pipeline constants and types for the AddRoundKey stage.
package add_round_key_stage_pkg;

  localparam int AES_NUM_ROUNDS_128 = 10;
  localparam int AES_NUM_ROUNDS_192 = 12;
  localparam int AES_NUM_ROUNDS_256 = 14;
  localparam int AES_DATA_WIDTH     = 128;

  typedef logic [AES_DATA_WIDTH-1:0] aes_state_t;
  typedef logic [AES_DATA_WIDTH-1:0] aes_key_t;

  // Index width wide enough to address round keys 0..num_rounds.
  function automatic int round_idx_w(input int num_rounds);
    return $clog2(num_rounds + 1);
  endfunction

endpackage

// File: rtl/add_round_key_stage_if.sv
// Key-load port plus valid/ready state stream for the AddRoundKey stage.
interface add_round_key_stage_if
  import add_round_key_stage_pkg::*;
#(
  parameter int DATA_WIDTH = AES_DATA_WIDTH,
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS_128
);
  localparam int RW = round_idx_w(NUM_ROUNDS);

  logic                  key_wr_en;
  logic [RW-1:0]         key_wr_addr;
  logic [DATA_WIDTH-1:0] key_wr_data;
  logic                  key_wr_err;
  logic                  keys_loaded;

  logic                  ark_valid_in;
  logic                  ark_ready_out;
  logic [DATA_WIDTH-1:0] state_in;

  logic                  ark_valid_out;
  logic                  ark_ready_in;
  logic [DATA_WIDTH-1:0] state_out;
  logic [RW-1:0]         round_out;
  logic                  last_out;

  modport master (
    output key_wr_en, key_wr_addr, key_wr_data, ark_valid_in, state_in, ark_ready_in,
    input  key_wr_err, keys_loaded, ark_ready_out, ark_valid_out, state_out, round_out, last_out
  );

  modport slave (
    input  key_wr_en, key_wr_addr, key_wr_data, ark_valid_in, state_in, ark_ready_in,
    output key_wr_err, keys_loaded, ark_ready_out, ark_valid_out, state_out, round_out, last_out
  );

endinterface

// File: rtl/add_round_key_stage_round_key_store.sv
// Round-key register file: one write port, combinational read, per-entry loaded mask.
module round_key_store #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_ROUNDS = 10,
  parameter int RW         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [RW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [RW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [NUM_ROUNDS:0]   mask
);

  logic [NUM_ROUNDS:0][DATA_WIDTH-1:0] keys;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keys <= '0;
      mask <= '0;
    end else if (clr) begin
      keys <= '0;
      mask <= '0;
    end else begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        if (wr_en && (wr_addr == RW'(i))) begin
          keys[i] <= wr_data;
          mask[i] <= 1'b1;
        end
      end
    end
  end

  // rd_addr is the round counter, which never exceeds NUM_ROUNDS.
  assign rd_data = keys[rd_addr];

endmodule

// File: rtl/add_round_key_stage.sv
// AES AddRoundKey pipeline stage: state ^ key[round], 1-cycle registered, valid/ready.
// Optional ARK_KEY_ZEROIZE_EN adds a key_zeroize input that wipes keys and in-flight state.
module add_round_key_stage
  import add_round_key_stage_pkg::*;
#(
  parameter int DATA_WIDTH = AES_DATA_WIDTH,
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS_128
) (
  input logic clk,
  input logic rst,
`ifdef ARK_KEY_ZEROIZE_EN
  input logic key_zeroize,
`endif
  add_round_key_stage_if.slave ark
);

  localparam int            RW       = round_idx_w(NUM_ROUNDS);
  localparam logic [RW-1:0] LAST_RND = RW'(NUM_ROUNDS);

  logic                  zeroize;
  logic [RW-1:0]         round_cnt;
  logic [DATA_WIDTH-1:0] rnd_key;
  logic [NUM_ROUNDS:0]   key_mask;

  logic                  vld_q;
  logic [DATA_WIDTH-1:0] state_q;
  logic [RW-1:0]         round_q;
  logic                  last_q;
  logic                  err_q;

  logic busy, addr_ok, key_wr_ok, keys_loaded, ready, accept, drain;

`ifdef ARK_KEY_ZEROIZE_EN
  assign zeroize = key_zeroize;
`else
  assign zeroize = 1'b0;
`endif

  // Keys may only change between blocks so a block never mixes old and new keys.
  assign busy        = (round_cnt != '0) || vld_q;
  assign addr_ok     = (ark.key_wr_addr <= LAST_RND);
  assign key_wr_ok   = ark.key_wr_en && !busy && addr_ok && !zeroize;
  assign keys_loaded = &key_mask;

  assign ready  = keys_loaded && !ark.key_wr_en && !zeroize && (!vld_q || ark.ark_ready_in);
  assign accept = ark.ark_valid_in && ready;
  assign drain  = vld_q && ark.ark_ready_in;

  round_key_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_ROUNDS (NUM_ROUNDS),
    .RW         (RW)
  ) u_key_store (
    .clk     (clk),
    .rst     (rst),
    .clr     (zeroize),
    .wr_en   (key_wr_ok),
    .wr_addr (ark.key_wr_addr),
    .wr_data (ark.key_wr_data),
    .rd_addr (round_cnt),
    .rd_data (rnd_key),
    .mask    (key_mask)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      round_cnt <= '0;
      vld_q     <= 1'b0;
      state_q   <= '0;
      round_q   <= '0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= ark.key_wr_en && !zeroize && !key_wr_ok;
      if (zeroize) begin
        round_cnt <= '0;
        vld_q     <= 1'b0;
        state_q   <= '0;
        round_q   <= '0;
        last_q    <= 1'b0;
      end else if (accept) begin
        state_q   <= ark.state_in ^ rnd_key;
        round_q   <= round_cnt;
        last_q    <= (round_cnt == LAST_RND);
        vld_q     <= 1'b1;
        round_cnt <= (round_cnt == LAST_RND) ? '0 : round_cnt + RW'(1);
      end else if (drain) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign ark.ark_ready_out = ready;
  assign ark.ark_valid_out = vld_q;
  assign ark.state_out     = state_q;
  assign ark.round_out     = round_q;
  assign ark.last_out      = last_q;
  assign ark.key_wr_err    = err_q;
  assign ark.keys_loaded   = keys_loaded;

endmodule
